dmem_responder: RTL and testbench

- Data-memory responder: the target end of the CPU core's DMEM interface (address_DMEM, write_data_DMEM, MemRead, MemWrite, data_DMEM).
- Holds a word-organised RAM and services byte, halfword and word loads and stores, with sign or zero extension on loads.
- Inserts a configurable number of wait states and reports them on a stall output; the core holds PC and its request while stall is high.
- Detects misaligned and illegal-size accesses.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - DMEM target: word RAM with sub-word access, wait states and fault detection
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       write_data_DMEM,
  output logic [31:0]       data_DMEM,
  output logic              stall,
  output logic              misaligned
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];

  logic              req;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic              acc_wr;
  logic              acc_fault;
  logic              enter_resp;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       lane_data;

  assign req = MemRead | MemWrite;

  // In IDLE the access is described by the live inputs (needed when WAIT_STATES=0),
  // afterwards by the latched copy, since the core's request is no longer trusted.
  always_comb begin
    acc_addr = addr_q;
    acc_size = size_q;
    acc_uns  = uns_q;
    acc_wr   = wr_q;
    if (state == S_IDLE) begin
      acc_addr = address_DMEM;
      acc_size = size;
      acc_uns  = unsigned_ld;
      acc_wr   = MemWrite;
    end
  end

  assign acc_fault = (acc_size == 2'b11) ||
                     ((acc_size == 2'b01) && acc_addr[0]) ||
                     ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));

  assign enter_resp = ((state == S_IDLE) && req && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  assign rd_word  = mem[acc_addr[ADDR_W-1:2]];
  assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
  assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (acc_size)
      2'b00:   load_val = {{24{~acc_uns & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{~acc_uns & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  assign stall = !RST && (((state == S_IDLE) && req) || (state == S_WAIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      data_DMEM  <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= enter_resp && acc_fault;
      if (enter_resp) begin
        if (acc_fault) begin
          data_DMEM <= 32'd0;
        end else if (!acc_wr) begin
          data_DMEM <= load_val;
        end
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= address_DMEM;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            wr_q    <= MemWrite;
            wdata_q <= write_data_DMEM;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stores commit on the edge leaving RESP; a reset at that edge drops them.
  always_ff @(posedge CLK) begin
    if (!RST && (state == S_RESP) && wr_q && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (WAIT_STATES 2 and 0)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr0, mw0, mr1, mw1;
  logic [9:0]  addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic [31:0] data0, data1;
  logic        stall0, stall1, mis0, mis1;

  logic        cur;
  logic [31:0] o_data;
  logic        o_stall, o_mis;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut0 (
    .CLK(clk), .RST(rst), .MemRead(mr0), .MemWrite(mw0), .address_DMEM(addr),
    .size(size), .unsigned_ld(uns), .write_data_DMEM(wdata),
    .data_DMEM(data0), .stall(stall0), .misaligned(mis0)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut1 (
    .CLK(clk), .RST(rst), .MemRead(mr1), .MemWrite(mw1), .address_DMEM(addr),
    .size(size), .unsigned_ld(uns), .write_data_DMEM(wdata),
    .data_DMEM(data1), .stall(stall1), .misaligned(mis1)
  );

  always_comb begin
    o_data  = cur ? data1  : data0;
    o_stall = cur ? stall1 : stall0;
    o_mis   = cur ? mis1   : mis0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete core request: hold it through the stall, check the RESP cycle, then release.
  task automatic access(input logic sel, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input int exp_stall, input logic [31:0] exp_data, input logic exp_mis,
                        input string tag);
    int n;
    int early_mis;
    cur = sel;
    @(negedge clk);
    addr = a; size = sz; uns = u; wdata = wd;
    if (sel) begin mr1 = rd; mw1 = wr; end
    else     begin mr0 = rd; mw0 = wr; end
    #1;
    n = 0;
    early_mis = 0;
    while (o_stall === 1'b1 && n < 40) begin
      if (o_mis !== 1'b0) early_mis++;
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, n, exp_stall);
    check({tag, " mis_during_stall"}, early_mis, 0);
    check({tag, " data"}, o_data, exp_data);
    check({tag, " misaligned"}, {31'd0, o_mis}, {31'd0, exp_mis});
    @(negedge clk);
    mr0 = 0; mw0 = 0; mr1 = 0; mw1 = 0;
    #1;
    check({tag, " mis_after"}, {31'd0, o_mis}, 32'd0);
  endtask

  initial begin
    rst = 1; mr0 = 0; mw0 = 0; mr1 = 0; mw1 = 0;
    addr = '0; size = 2'b10; uns = 0; wdata = '0; cur = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset data0", data0, 32'd0);
    check("reset stall0", {31'd0, stall0}, 32'd0);
    check("reset mis0", {31'd0, mis0}, 32'd0);
    check("reset data1", data1, 32'd0);
    rst = 0;

    access(0, 0, 1, 10'h010, 2'b10, 0, 32'hDEADBEEF, 3, 32'h00000000, 0, "sw_010");
    access(0, 1, 0, 10'h010, 2'b10, 0, 32'h0,        3, 32'hDEADBEEF, 0, "lw_010");

    access(0, 0, 1, 10'h013, 2'b00, 0, 32'h00000080, 3, 32'hDEADBEEF, 0, "sb_013");
    access(0, 1, 0, 10'h013, 2'b00, 0, 32'h0,        3, 32'hFFFFFF80, 0, "lb_013");
    access(0, 1, 0, 10'h013, 2'b00, 1, 32'h0,        3, 32'h00000080, 0, "lbu_013");
    access(0, 1, 0, 10'h010, 2'b10, 0, 32'h0,        3, 32'h80ADBEEF, 0, "lw_010b");

    access(0, 0, 1, 10'h010, 2'b10, 0, 32'hDEADBEEF, 3, 32'h80ADBEEF, 0, "sw_010b");
    access(0, 0, 1, 10'h012, 2'b01, 0, 32'h00001234, 3, 32'h80ADBEEF, 0, "sh_012");
    access(0, 1, 0, 10'h012, 2'b01, 0, 32'h0,        3, 32'h00001234, 0, "lh_012");
    access(0, 1, 0, 10'h010, 2'b10, 0, 32'h0,        3, 32'h1234BEEF, 0, "lw_010c");
    access(0, 0, 1, 10'h010, 2'b01, 0, 32'h00008001, 3, 32'h1234BEEF, 0, "sh_010");
    access(0, 1, 0, 10'h010, 2'b01, 1, 32'h0,        3, 32'h00008001, 0, "lhu_010");
    access(0, 1, 0, 10'h010, 2'b01, 0, 32'h0,        3, 32'hFFFF8001, 0, "lh_010");

    access(0, 1, 0, 10'h011, 2'b10, 0, 32'h0,        3, 32'h00000000, 1, "lw_011_fault");
    access(0, 0, 1, 10'h004, 2'b10, 0, 32'h11111111, 3, 32'h00000000, 0, "sw_004");
    access(0, 0, 1, 10'h006, 2'b10, 0, 32'h00000055, 3, 32'h00000000, 1, "sw_006_fault");
    access(0, 1, 0, 10'h004, 2'b10, 0, 32'h0,        3, 32'h11111111, 0, "lw_004");
    access(0, 1, 0, 10'h008, 2'b11, 0, 32'h0,        3, 32'h00000000, 1, "size11_fault");

    access(0, 0, 1, 10'h020, 2'b10, 0, 32'h00000000, 3, 32'h00000000, 0, "sw_020_zero");
    access(0, 1, 0, 10'h004, 2'b10, 0, 32'h0,        3, 32'h11111111, 0, "lw_004b");

    // Store aborted by reset while in WAIT.
    cur = 0;
    @(negedge clk);
    addr = 10'h020; size = 2'b10; uns = 0; wdata = 32'hCAFEF00D; mw0 = 1;
    #1;
    check("rst_store stall_idle", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_store stall_in_reset", {31'd0, stall0}, 32'd0);
    @(negedge clk);
    rst = 0; mw0 = 0;
    #1;
    check("rst_store stall_after", {31'd0, stall0}, 32'd0);
    check("rst_store data_after", data0, 32'd0);
    check("rst_store mis_after", {31'd0, mis0}, 32'd0);
    access(0, 1, 0, 10'h020, 2'b10, 0, 32'h0,        3, 32'h00000000, 0, "lw_020_after_rst");

    access(0, 1, 0, 10'h004, 2'b10, 0, 32'h0,        3, 32'h11111111, 0, "lw_004c");
    access(0, 1, 1, 10'h030, 2'b10, 0, 32'h0000ABCD, 3, 32'h11111111, 0, "rdwr_030");
    access(0, 1, 0, 10'h030, 2'b10, 0, 32'h0,        3, 32'h0000ABCD, 0, "lw_030");

    access(1, 1, 1, 10'h030, 2'b10, 0, 32'h0000ABCD, 1, 32'h00000000, 0, "ws0_rdwr_030");
    access(1, 1, 0, 10'h030, 2'b10, 0, 32'h0,        1, 32'h0000ABCD, 0, "ws0_lw_030");
    access(1, 1, 0, 10'h031, 2'b01, 0, 32'h0,        1, 32'h00000000, 1, "ws0_lh_031_fault");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
